// File: rtl/seq_pkg.sv
// Shared definitions for the microcode sequencer:
// opcodes, control-word bit positions and the control-word type.
package seq_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_STA = 4'd4;
  localparam logic [3:0] OP_LDI = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JC  = 4'd7;
  localparam logic [3:0] OP_JZ  = 4'd8;
  localparam logic [3:0] OP_JNZ = 4'd9;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  localparam int CB_HLT  = 15;
  localparam int CB_MI   = 14;
  localparam int CB_RI   = 13;
  localparam int CB_RO   = 12;
  localparam int CB_IO   = 11;
  localparam int CB_II   = 10;
  localparam int CB_AI   = 9;
  localparam int CB_AO   = 8;
  localparam int CB_SUMO = 7;
  localparam int CB_SUB  = 6;
  localparam int CB_BI   = 5;
  localparam int CB_OI   = 4;
  localparam int CB_CE   = 3;
  localparam int CB_CO   = 2;
  localparam int CB_J    = 1;
  localparam int CB_FI   = 0;

  typedef struct packed {
    logic hlt;
    logic mi;
    logic ri;
    logic ro;
    logic io;
    logic ii;
    logic ai;
    logic ao;
    logic sumo;
    logic sub;
    logic bi;
    logic oi;
    logic ce;
    logic co;
    logic j;
    logic fi;
  } ctrl_t;

  function automatic logic [15:0] cb(input int idx);
    return 16'(1) << idx;
  endfunction

  localparam logic [15:0] W_HLT = 16'h8000;
  localparam logic [15:0] W_MI  = 16'h4000;
  localparam logic [15:0] W_RI  = 16'h2000;
  localparam logic [15:0] W_RO  = 16'h1000;
  localparam logic [15:0] W_IO  = 16'h0800;
  localparam logic [15:0] W_II  = 16'h0400;
  localparam logic [15:0] W_AI  = 16'h0200;
  localparam logic [15:0] W_AO  = 16'h0100;
  localparam logic [15:0] W_SUM = 16'h0080;
  localparam logic [15:0] W_SUB = 16'h0040;
  localparam logic [15:0] W_BI  = 16'h0020;
  localparam logic [15:0] W_OI  = 16'h0010;
  localparam logic [15:0] W_CE  = 16'h0008;
  localparam logic [15:0] W_CO  = 16'h0004;
  localparam logic [15:0] W_J   = 16'h0002;
  localparam logic [15:0] W_FI  = 16'h0001;

  localparam logic [15:0] W_FETCH0 = W_MI | W_CO;
  localparam logic [15:0] W_FETCH1 = W_RO | W_II | W_CE;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode table: (opcode, step, flags) -> control word
// plus a flag marking the opcode's last defined step.
module microcode_rom
  import seq_pkg::*;
#(
  parameter int OPC_W = 4,
  parameter int SW    = 3
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [SW-1:0]    step,
  input  logic             cf,
  input  logic             zf,
  output ctrl_t            word,
  output logic             last
);

  logic [15:0] e0;
  logic [15:0] e1;
  logic [15:0] e2;
  logic [2:0]  n;
  logic [3:0]  s;
  logic [15:0] w;

  always_comb begin
    e0 = '0;
    e1 = '0;
    e2 = '0;
    n  = 3'd0;
    unique case (1'b1)
      opcode == OPC_W'(OP_LDA): begin
        n  = 3'd2;
        e0 = W_MI | W_IO;
        e1 = W_RO | W_AI;
      end
      opcode == OPC_W'(OP_ADD): begin
        n  = 3'd3;
        e0 = W_MI | W_IO;
        e1 = W_RO | W_BI;
        e2 = W_AI | W_SUM | W_FI;
      end
      opcode == OPC_W'(OP_SUB): begin
        n  = 3'd3;
        e0 = W_MI | W_IO;
        e1 = W_RO | W_BI;
        e2 = W_AI | W_SUM | W_SUB | W_FI;
      end
      opcode == OPC_W'(OP_STA): begin
        n  = 3'd2;
        e0 = W_MI | W_IO;
        e1 = W_AO | W_RI;
      end
      opcode == OPC_W'(OP_LDI): begin
        n  = 3'd1;
        e0 = W_IO | W_AI;
      end
      opcode == OPC_W'(OP_JMP): begin
        n  = 3'd1;
        e0 = W_IO | W_J;
      end
      opcode == OPC_W'(OP_JC): begin
        n  = 3'd1;
        e0 = cf ? (W_IO | W_J) : 16'h0;
      end
      opcode == OPC_W'(OP_JZ): begin
        n  = 3'd1;
        e0 = zf ? (W_IO | W_J) : 16'h0;
      end
      opcode == OPC_W'(OP_JNZ): begin
        n  = 3'd1;
        e0 = !zf ? (W_IO | W_J) : 16'h0;
      end
      opcode == OPC_W'(OP_OUT): begin
        n  = 3'd1;
        e0 = W_AO | W_OI;
      end
      opcode == OPC_W'(OP_HLT): begin
        n  = 3'd1;
        e0 = W_HLT;
      end
      default: begin
        n = 3'd0;
      end
    endcase
  end

  always_comb begin
    s = 4'(step);
    w = '0;
    if (s == 4'd0)
      w = W_FETCH0;
    else if (s == 4'd1)
      w = W_FETCH1;
    else if (s == 4'd2 && n > 3'd0)
      w = e0;
    else if (s == 4'd3 && n > 3'd1)
      w = e1;
    else if (s == 4'd4 && n > 3'd2)
      w = e2;
  end

  assign word = ctrl_t'(w);
  assign last = (s == ({1'b0, n} + 4'd1));

endmodule

// File: rtl/microcode_sequencer.sv
// Microstep counter, halt latch and registered control outputs;
// all state moves on the falling clock edge.
module microcode_sequencer
  import seq_pkg::*;
#(
  parameter int INSN_W    = 8,
  parameter int OPC_W     = 4,
  parameter int MAX_STEPS = 6,
  parameter int EARLY_END = 1,
  localparam int SW       = $clog2(MAX_STEPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INSN_W-1:0] insn,
  input  logic              prog_mode,
  input  logic              cf,
  input  logic              zf,
  output logic [15:0]       ctrl,
  output logic [SW-1:0]     step,
  output logic              insn_done,
  output logic              halted
);

  localparam logic [SW-1:0] LAST = SW'(MAX_STEPS - 1);

  logic [SW-1:0] cnt;
  ctrl_t         rom_word;
  logic          rom_last;
  logic          wrap;
  logic          unused_insn;

  // Operand bits travel on the bus; only the opcode reaches the ROM.
  assign unused_insn = ^insn;

  microcode_rom #(
    .OPC_W (OPC_W),
    .SW    (SW)
  ) u_rom (
    .opcode (insn[INSN_W-1 -: OPC_W]),
    .step   (cnt),
    .cf     (cf),
    .zf     (zf),
    .word   (rom_word),
    .last   (rom_last)
  );

  assign wrap = (cnt == LAST) || ((EARLY_END != 0) && rom_last);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      ctrl      <= '0;
      step      <= '0;
      insn_done <= 1'b0;
      halted    <= 1'b0;
      cnt       <= '0;
    end else if (halted) begin
      insn_done <= 1'b0;
    end else if (prog_mode) begin
      ctrl      <= '0;
      step      <= '0;
      insn_done <= 1'b0;
      cnt       <= '0;
    end else begin
      ctrl      <= rom_word;
      step      <= cnt;
      insn_done <= wrap;
      cnt       <= wrap ? '0 : cnt + SW'(1);
      if (rom_word.hlt)
        halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: three instances cover
// early-end, fixed-length and truncated step ceilings.
module tb_microcode_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] insn = 8'h00;
  logic       prog_mode = 1'b1;
  logic       cf = 1'b0;
  logic       zf = 1'b0;

  logic [15:0] ctrl_a, ctrl_b, ctrl_c;
  logic [2:0]  step_a, step_b;
  logic [1:0]  step_c;
  logic        done_a, done_b, done_c;
  logic        halt_a, halt_b, halt_c;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  microcode_sequencer #(.MAX_STEPS(6), .EARLY_END(1)) dut_a (
    .clk(clk), .rst(rst), .insn(insn), .prog_mode(prog_mode),
    .cf(cf), .zf(zf), .ctrl(ctrl_a), .step(step_a),
    .insn_done(done_a), .halted(halt_a));

  microcode_sequencer #(.MAX_STEPS(6), .EARLY_END(0)) dut_b (
    .clk(clk), .rst(rst), .insn(insn), .prog_mode(prog_mode),
    .cf(cf), .zf(zf), .ctrl(ctrl_b), .step(step_b),
    .insn_done(done_b), .halted(halt_b));

  microcode_sequencer #(.MAX_STEPS(3), .EARLY_END(1)) dut_c (
    .clk(clk), .rst(rst), .insn(insn), .prog_mode(prog_mode),
    .cf(cf), .zf(zf), .ctrl(ctrl_c), .step(step_c),
    .insn_done(done_c), .halted(halt_c));

  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({ctrl_a, step_a, done_a, halt_a} !== 21'h0) begin
      $display("FAIL reset ctrl=%h step=%0d done=%b halt=%b want 0",
               ctrl_a, step_a, done_a, halt_a);
      n_bad++;
    end
  endtask

  task automatic test_lda();
    logic [15:0] ec[5] = '{16'h4004, 16'h1408, 16'h4800, 16'h1200, 16'h4004};
    logic        ed[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  es[5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    insn = 8'h1F;
    prog_mode = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_cmp++;
      if (ctrl_a !== ec[i] || done_a !== ed[i] || step_a !== es[i]) begin
        $display("FAIL lda[%0d] got %h/%b/%0d want %h/%b/%0d", i,
                 ctrl_a, done_a, step_a, ec[i], ed[i], es[i]);
        n_bad++;
      end
    end
  endtask

  task automatic test_add_lengths();
    logic [15:0] eca[6] = '{16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0281, 16'h4004};
    logic        eda[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] ecb[6] = '{16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0281, 16'h0000};
    logic        edb[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] ecc[6] = '{16'h4004, 16'h1408, 16'h4800, 16'h4004, 16'h1408, 16'h4800};
    logic        edc[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    insn = 8'h2A;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_cmp++;
      if (ctrl_a !== eca[i] || done_a !== eda[i]) begin
        $display("FAIL add_early[%0d] got %h/%b want %h/%b", i,
                 ctrl_a, done_a, eca[i], eda[i]);
        n_bad++;
      end
      n_cmp++;
      if (ctrl_b !== ecb[i] || done_b !== edb[i] || step_b !== 3'(i)) begin
        $display("FAIL add_fixed[%0d] got %h/%b/%0d want %h/%b/%0d", i,
                 ctrl_b, done_b, step_b, ecb[i], edb[i], i);
        n_bad++;
      end
      n_cmp++;
      if (ctrl_c !== ecc[i] || done_c !== edc[i]) begin
        $display("FAIL add_trunc[%0d] got %h/%b want %h/%b", i,
                 ctrl_c, done_c, ecc[i], edc[i]);
        n_bad++;
      end
    end
  endtask

  task automatic test_jumps();
    logic [7:0]  ti[4] = '{8'h70, 8'h70, 8'h80, 8'h90};
    logic        tc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic        tz[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] ew[4] = '{16'h0000, 16'h0802, 16'h0802, 16'h0000};
    insn = 8'h70;
    cf = 1'b0;
    zf = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      insn = ti[k];
      cf = tc[k];
      zf = tz[k];
      cyc();
      cyc();
      cyc();
      n_cmp++;
      if (ctrl_a !== ew[k] || done_a !== 1'b1 || step_a !== 3'd2) begin
        $display("FAIL jump[%0d] got %h/%b/%0d want %h/1/2", k,
                 ctrl_a, done_a, step_a, ew[k]);
        n_bad++;
      end
    end
    cf = 1'b0;
    zf = 1'b0;
  endtask

  task automatic test_short_ops();
    logic [7:0]  ti[5] = '{8'h4A, 8'h5F, 8'hE0, 8'h00, 8'hB0};
    int          tl[5] = '{4, 3, 3, 2, 2};
    logic [15:0] ew[5] = '{16'h2100, 16'h0A00, 16'h0110, 16'h1408, 16'h1408};
    insn = 8'h4A;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      insn = ti[k];
      cyc();
      n_cmp++;
      if (ctrl_a !== 16'h4004 || done_a !== 1'b0) begin
        $display("FAIL op%h_first got %h/%b want 4004/0",
                 ti[k], ctrl_a, done_a);
        n_bad++;
      end
      for (int c = 1; c < tl[k]; c++)
        cyc();
      n_cmp++;
      if (ctrl_a !== ew[k] || done_a !== 1'b1) begin
        $display("FAIL op%h_last got %h/%b want %h/1",
                 ti[k], ctrl_a, done_a, ew[k]);
        n_bad++;
      end
    end
    cyc();
    n_cmp++;
    if (ctrl_a !== 16'h4004 || done_a !== 1'b0) begin
      $display("FAIL undef_next got %h/%b want 4004/0", ctrl_a, done_a);
      n_bad++;
    end
  endtask

  task automatic test_prog_mode();
    insn = 8'h30;
    do_reset();
    cyc();
    cyc();
    cyc();
    cyc();
    n_cmp++;
    if (ctrl_a !== 16'h1020 || step_a !== 3'd3) begin
      $display("FAIL sub_step3 got %h/%0d want 1020/3", ctrl_a, step_a);
      n_bad++;
    end
    prog_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if (ctrl_a !== 16'h0 || step_a !== 3'd0 || done_a !== 1'b0) begin
        $display("FAIL prog[%0d] got %h/%0d/%b want 0000/0/0", i,
                 ctrl_a, step_a, done_a);
        n_bad++;
      end
    end
    prog_mode = 1'b0;
    cyc();
    n_cmp++;
    if (ctrl_a !== 16'h4004 || step_a !== 3'd0) begin
      $display("FAIL prog_release got %h/%0d want 4004/0", ctrl_a, step_a);
      n_bad++;
    end
  endtask

  task automatic test_halt();
    insn = 8'hF0;
    do_reset();
    cyc();
    cyc();
    cyc();
    n_cmp++;
    if (ctrl_a !== 16'h8000 || halt_a !== 1'b1) begin
      $display("FAIL hlt_word got %h/%b want 8000/1", ctrl_a, halt_a);
      n_bad++;
    end
    for (int i = 0; i < 12; i++) begin
      prog_mode = (i >= 3 && i < 7);
      cyc();
      n_cmp++;
      if (ctrl_a !== 16'h8000 || halt_a !== 1'b1 || step_a !== 3'd2) begin
        $display("FAIL halted[%0d] got %h/%b/%0d want 8000/1/2", i,
                 ctrl_a, halt_a, step_a);
        n_bad++;
      end
    end
    prog_mode = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({ctrl_a, step_a, done_a, halt_a} !== 21'h0) begin
      $display("FAIL halt_reset got %h/%0d/%b/%b want 0", ctrl_a,
               step_a, done_a, halt_a);
      n_bad++;
    end
    #1;
    rst = 1'b1;
    cyc();
    n_cmp++;
    if (ctrl_a !== 16'h4004 || halt_a !== 1'b0) begin
      $display("FAIL post_reset got %h/%b want 4004/0", ctrl_a, halt_a);
      n_bad++;
    end
  endtask

  initial begin
    test_reset();
    test_lda();
    test_add_lengths();
    test_jumps();
    test_short_ops();
    test_prog_mode();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
